// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the 4-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned HOLD_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arb4_mux41.sv
// 4:1 single-bit multiplexer used for the arbiter's data path.
module mux41 (
  input  logic [3:0] a,
  input  logic [1:0] s,
  output logic       y
);

  assign y = a[s];

endmodule

// File: rtl/rr_arb4.sv
// Round-robin arbiter for four requesters with a bounded hold time per owner
// and a registered grant driving a 1-bit data mux.
module rr_arb4
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] d,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             y
);

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [N_REQ-1:0]  others;
  logic [SEL_W:0]    cand;
  logic              search_en;
  logic              mux_y;

  // Returns {found, index} of the first set bit at or after start, wrapping.
  function automatic logic [SEL_W:0] next_grant(input logic [N_REQ-1:0] mask,
                                                 input logic [SEL_W-1:0] start);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      idx = start + SEL_W'(i - 1);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    search_en = 1'b0;

    others        = req;
    others[sel_q] = 1'b0;

    case (state_q)
      IDLE: search_en = 1'b1;
      BUSY: begin
        if (req[sel_q] && (hold_q < HOLD_LAST || others == '0)) begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
        end else begin
          search_en = 1'b1;
        end
      end
      default: search_en = 1'b1;
    endcase

    // In IDLE sel_q's bit is not requesting-owner, but excluding it is harmless
    // only in BUSY; IDLE must search the full request vector.
    cand = next_grant((state_q == BUSY) ? others : req, ptr_q);

    if (search_en) begin
      if (cand[SEL_W]) begin
        state_d           = BUSY;
        sel_d             = cand[SEL_W-1:0];
        gnt_d             = '0;
        gnt_d[sel_d]      = 1'b1;
        valid_d           = 1'b1;
        ptr_d             = cand[SEL_W-1:0] + SEL_W'(1);
        hold_d            = '0;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  mux41 u_mux (
    .a (d),
    .s (sel_q),
    .y (mux_y)
  );

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign y     = valid_q & mux_y;

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: two instances (hold limits 4 and 1) against an integer-level
// round-robin model, plus directed literal scenarios.
module tb_rr_arb4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = 4'b1111;
  logic [3:0] d     = 4'b0000;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b;
  logic       valid_a, valid_b, y_a, y_b;

  int checks = 0;
  int errors = 0;

  int mh_of[2]    = '{4, 1};
  int m_owner[2]  = '{-1, -1};
  int m_ptr[2]    = '{0, 0};
  int m_held[2]   = '{0, 0};
  int wait_cnt[4] = '{0, 0, 0, 0};

  rr_arb4 #(.MAX_HOLD(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gnt_a), .sel(sel_a), .valid(valid_a), .y(y_a)
  );

  rr_arb4 #(.MAX_HOLD(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gnt_b), .sel(sel_b), .valid(valid_b), .y(y_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One arbitration decision: the owner keeps the grant while requesting and
  // either under its cycle budget or alone; otherwise the next requester at or
  // after the pointer (never the current owner) takes over.
  task automatic model_step(input int k, input logic [3:0] r);
    int cur, pick, idx;
    bit waiting;
    cur = m_owner[k];
    waiting = 0;
    for (int j = 0; j < 4; j++) if (r[j] && j != cur) waiting = 1;
    if (cur >= 0 && r[cur[1:0]] && (m_held[k] < mh_of[k] || !waiting)) begin
      m_held[k]++;
    end else begin
      pick = -1;
      for (int j = 0; j < 4; j++) begin
        idx = (m_ptr[k] + j) % 4;
        if (pick < 0 && r[idx[1:0]] && idx != cur) pick = idx;
      end
      if (pick >= 0) begin
        m_owner[k] = pick;
        m_held[k]  = 1;
        m_ptr[k]   = (pick + 1) % 4;
      end else begin
        m_owner[k] = -1;
        m_held[k]  = 0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_owner[k] = -1;
        m_ptr[k]   = 0;
        m_held[k]  = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k, req);
    end
  end

  task automatic cmp_inst(input int k, input logic [3:0] g, input logic [1:0] s,
                          input logic v, input logic yy);
    int own;
    int exp_g;
    int exp_y;
    own   = m_owner[k];
    exp_g = (own >= 0) ? (1 << own) : 0;
    exp_y = (own >= 0) ? int'(d[own[1:0]]) : 0;
    check($sformatf("gnt%0d", k), int'(g), exp_g);
    check($sformatf("valid%0d", k), int'(v), int'(own >= 0));
    check($sformatf("y%0d", k), int'(yy), exp_y);
    check($sformatf("onehot%0d", k), int'($onehot0(g)), 1);
    if (own >= 0) check($sformatf("sel%0d", k), int'(s), own);
  endtask

  always @(negedge clk) begin
    cmp_inst(0, gnt_a, sel_a, valid_a, y_a);
    cmp_inst(1, gnt_b, sel_b, valid_b, y_b);
    for (int i = 0; i < 4; i++) begin
      if (rst_n && req[i] && !gnt_a[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      check($sformatf("starve%0d", i), int'(wait_cnt[i] <= 12), 1);
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] flip;

    // Reset with all requesting; release mid-cycle.
    repeat (2) nxt();
    check("reset_gnt", int'(gnt_a), 0);
    check("reset_valid", int'(valid_a), 0);
    rst_n = 1'b1;
    for (int n = 0; n <= 16; n++) begin
      nxt();
      check("rot4_sel", int'(sel_a), (n / 4) % 4);
      check("rot4_gnt", int'(gnt_a), 1 << ((n / 4) % 4));
      check("rot1_sel", int'(sel_b), n % 4);
    end

    // Single requester: held indefinitely, then released.
    req = 4'b0100;
    for (int n = 0; n < 10; n++) begin
      nxt();
      check("solo_gnt", int'(gnt_a), 4);
    end
    req = 4'b0000;
    nxt();
    check("solo_drop_gnt", int'(gnt_a), 0);
    check("solo_drop_valid", int'(valid_a), 0);

    // Data mux follows live d of the owner in the same cycle.
    req = 4'b0010;
    nxt();
    check("mux_owner", int'(sel_a), 1);
    d = 4'b0010;
    #1;
    check("mux_y_hi", int'(y_a), 1);
    nxt();
    d = 4'b0000;
    #1;
    check("mux_y_lo", int'(y_a), 0);
    req = 4'b0000;
    d   = 4'b1111;
    nxt();
    check("mux_gated_valid", int'(valid_a), 0);
    check("mux_gated_y", int'(y_a), 0);

    // Wrap 3 -> 0, pointer then at 1.
    req = 4'b1000;
    nxt();
    check("wrap_own3", int'(sel_a), 3);
    req = 4'b0001;
    nxt();
    check("wrap_gnt0", int'(gnt_a), 1);
    req = 4'b0000;
    nxt();
    check("wrap_idle", int'(valid_a), 0);
    req = 4'b1111;
    nxt();
    check("ptr_is_1", int'(sel_a), 1);

    // Asynchronous reset mid-grant.
    nxt();
    check("pre_rst_y", int'(y_a), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", int'(gnt_a), 0);
    check("async_valid", int'(valid_a), 0);
    check("async_y", int'(y_a), 0);
    check("async_gnt_b", int'(gnt_b), 0);
    nxt();
    rst_n = 1'b1;
    req   = 4'b1000;
    nxt();
    check("post_rst_gnt", int'(gnt_a), 8);
    check("post_rst_sel", int'(sel_a), 3);

    // Random traffic: fully random, then sticky requests with rare toggles.
    for (int c = 0; c < 3000; c++) begin
      nxt();
      req = 4'($urandom);
      d   = 4'($urandom);
    end
    for (int c = 0; c < 7000; c++) begin
      nxt();
      flip = '0;
      for (int i = 0; i < 4; i++) flip[i] = ($urandom_range(0, 9) == 0);
      req = req ^ flip;
      d   = 4'($urandom);
    end
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
